// File: rtl/ice40_serdes_gearbox_rx_pkg.sv
// ice40_serdes_gearbox_rx_pkg
//   Shared definitions for the receive gearbox: default beat/word widths and a
//   width helper that never returns zero, so single-value counters still get
//   one bit.
// Ports: none (package).
package ice40_serdes_gearbox_rx_pkg;

    localparam int DW_DEFAULT = 4;
    localparam int OW_DEFAULT = 10;

    // Bits needed to hold values 0..v-1, at least one.
    function automatic int width_of(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/ice40_serdes_gearbox_rx.sv
// ice40_serdes_gearbox_rx
//   Receive-side gearbox: packs DW-bit beats from the capture flops into OW-bit
//   words, oldest line bit in bit 0. A bitslip pulse arms a pending slip that
//   drops bit 0 of the next accepted beat, shifting word alignment by one bit.
// Ports:
//   clk_i        core clock, rising edge
//   rst_i        asynchronous active-high reset
//   in_data_i    input beat, bit 0 earliest on the line
//   in_valid_i   beat present this cycle
//   bitslip_i    single-cycle request to drop one line bit
//   out_data_o   last completed word (held between strobes)
//   out_valid_o  one-cycle strobe for a new word
//   slip_pos_o   slips applied, modulo OW
//   slip_busy_o  slip accepted but not yet applied
module ice40_serdes_gearbox_rx
    import ice40_serdes_gearbox_rx_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int OW = OW_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [DW-1:0]           in_data_i,
    input  logic                    in_valid_i,
    input  logic                    bitslip_i,
    output logic [OW-1:0]           out_data_o,
    output logic                    out_valid_o,
    output logic [width_of(OW)-1:0] slip_pos_o,
    output logic                    slip_busy_o
);

    // Buffer holds at most OW-1 leftover bits plus one full beat.
    localparam int BW = OW + DW - 1;
    localparam int CW = width_of(OW + DW);
    localparam int SW = width_of(OW);

    logic [BW-1:0] buf_q, buf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [OW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] slip_pos_q, slip_pos_d;
    logic          slip_busy_q, slip_busy_d;

    logic [BW-1:0] beat_bits;
    logic [CW-1:0] beat_n;
    logic [BW-1:0] merged;
    logic [CW-1:0] total;

    always_comb begin
        buf_d       = buf_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        slip_pos_d  = slip_pos_q;
        slip_busy_d = slip_busy_q;
        beat_bits   = '0;
        beat_n      = '0;
        merged      = '0;
        total       = '0;

        if (in_valid_i) begin
            if (slip_busy_q) begin
                // The earliest bit of this beat is the one that gets dropped.
                beat_bits   = BW'(in_data_i >> 1);
                beat_n      = CW'(DW - 1);
                slip_busy_d = 1'b0;
                slip_pos_d  = (slip_pos_q == SW'(OW - 1)) ? '0 : slip_pos_q + 1'b1;
            end else begin
                beat_bits = BW'(in_data_i);
                beat_n    = CW'(DW);
            end

            // Bits above cnt_q are always zero, so OR-ing the new beat in is safe.
            merged = buf_q | (beat_bits << cnt_q);
            total  = cnt_q + beat_n;

            if (total >= CW'(OW)) begin
                out_data_d  = merged[OW-1:0];
                out_valid_d = 1'b1;
                buf_d       = merged >> OW;
                cnt_d       = total - CW'(OW);
            end else begin
                buf_d = merged;
                cnt_d = total;
            end
        end

        // A request arriving while one is pending is dropped; one arriving with a
        // beat only arms the slip for the following beat.
        if (bitslip_i && !slip_busy_q) begin
            slip_busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            slip_pos_q  <= '0;
            slip_busy_q <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            slip_pos_q  <= slip_pos_d;
            slip_busy_q <= slip_busy_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign slip_pos_o  = slip_pos_q;
    assign slip_busy_o = slip_busy_q;

endmodule
